// File: rtl/axonerve_kvs_seq.sv
// rtl/axonerve_kvs_seq.sv - command sequencer and free-entry pool for the AXONERVE CAM
// Optional ACK watchdog and timeout counter: define AXONERVE_KVS_ACK_TIMEOUT_EN.
module axonerve_kvs_seq #(
  parameter int KEY_W   = 128,
  parameter int VAL_W   = 32,
  parameter int PRI_W   = 7,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 65536,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int TIMEOUT = 1023
) (
  input  logic              I_CLK,
  input  logic              I_XRST,
  output logic              O_READY,
  input  logic              I_CMD_VALID,
  output logic              O_CMD_READY,
  input  logic [2:0]        I_CMD_OP,
  input  logic [TAG_W-1:0]  I_CMD_TAG,
  input  logic [KEY_W-1:0]  I_KEY_DAT,
  input  logic [KEY_W-1:0]  I_EKEY_MSK,
  input  logic [PRI_W-1:0]  I_KEY_PRI,
  input  logic [VAL_W-1:0]  I_KEY_VALUE,
  output logic              O_RSP_VALID,
  input  logic              I_RSP_READY,
  output logic [TAG_W-1:0]  O_RSP_TAG,
  output logic [2:0]        O_RSP_OP,
  output logic [1:0]        O_RSP_STATUS,
  output logic [VAL_W-1:0]  O_RSP_VALUE,
  output logic [ADDR_W-1:0] O_RSP_ADDR,
  output logic [ADDR_W:0]   O_ENT_COUNT,
  output logic              O_ENT_FULL,
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
  output logic [15:0]       O_TIMEOUT_CNT,
`endif
  input  logic              I_CAM_READY,
  output logic              O_CAM_SE,
  output logic              O_CAM_WE,
  output logic              O_CAM_IE,
  output logic [ADDR_W-1:0] O_CAM_ADD,
  output logic [KEY_W-1:0]  O_CAM_KEY_DAT,
  output logic [KEY_W-1:0]  O_CAM_EKEY_MSK,
  output logic [PRI_W-1:0]  O_CAM_KEY_PRI,
  output logic [VAL_W-1:0]  O_CAM_KEY_VALUE,
  input  logic              I_CAM_ACK,
  input  logic              I_CAM_ENT_ERR,
  input  logic              I_CAM_SHIT,
  input  logic              I_CAM_MHIT,
  input  logic [ADDR_W-1:0] I_CAM_SRCH_ADD,
  input  logic [VAL_W-1:0]  I_CAM_KEY_VALUE
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [2:0] OP_SEARCH = 3'd0, OP_WRITE = 3'd1, OP_ERASE = 3'd2, OP_UPDATE = 3'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2, ST_ERR = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SRCH, S_WAIT_S, S_ISSUE_W, S_WAIT_W, S_RESP} state_t;

  state_t state_q, state_d;
  logic              ready_q, ready_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [KEY_W-1:0]  key_q, key_d, msk_q, msk_d;
  logic [PRI_W-1:0]  pri_q, pri_d;
  logic [VAL_W-1:0]  val_q, val_d, rsp_val_q, rsp_val_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
  logic              alloc_q, alloc_d, from_stk_q, from_stk_d;
  logic [1:0]        status_q, status_d;
  logic [CNT_W-1:0]  fresh_q, fresh_d, sp_q, sp_d;
  logic              push_en, cam_hit, pool_empty;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] stack_mem [DEPTH];

`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      tcnt_q, tcnt_d;
  assign O_TIMEOUT_CNT = tcnt_q;
`else
  // TIMEOUT only sizes the watchdog, which this build leaves out
  if (TIMEOUT < 0) begin : g_no_watchdog
  end
`endif

  assign stack_top  = stack_mem[ADDR_W'(sp_q - ONE_C)];
  assign pool_empty = (fresh_q == DEPTH_C) && (sp_q == '0);
  assign cam_hit    = (I_CAM_SHIT | I_CAM_MHIT) & ~I_CAM_ENT_ERR;

  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      state_q <= S_INIT;  ready_q <= 1'b0;  op_q <= '0;  tag_q <= '0;
      key_q <= '0;  msk_q <= '0;  pri_q <= '0;  val_q <= '0;
      addr_q <= '0;  alloc_q <= 1'b0;  from_stk_q <= 1'b0;
      status_q <= '0;  rsp_val_q <= '0;  rsp_addr_q <= '0;
      fresh_q <= '0;  sp_q <= '0;
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
      tmo_q <= '0;  tcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;  ready_q <= ready_d;  op_q <= op_d;  tag_q <= tag_d;
      key_q <= key_d;  msk_q <= msk_d;  pri_q <= pri_d;  val_q <= val_d;
      addr_q <= addr_d;  alloc_q <= alloc_d;  from_stk_q <= from_stk_d;
      status_q <= status_d;  rsp_val_q <= rsp_val_d;  rsp_addr_q <= rsp_addr_d;
      fresh_q <= fresh_d;  sp_q <= sp_d;
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
      tmo_q <= tmo_d;  tcnt_q <= tcnt_d;
`endif
    end
  end

  // Recycle stack contents are don't-care after reset; only sp_q defines validity
  always_ff @(posedge I_CLK) begin
    if (push_en) stack_mem[sp_q[ADDR_W-1:0]] <= addr_q;
  end

  always_comb begin
    state_d = state_q;  ready_d = ready_q;  op_d = op_q;  tag_d = tag_q;
    key_d = key_q;  msk_d = msk_q;  pri_d = pri_q;  val_d = val_q;
    addr_d = addr_q;  alloc_d = alloc_q;  from_stk_d = from_stk_q;
    status_d = status_q;  rsp_val_d = rsp_val_q;  rsp_addr_d = rsp_addr_q;
    fresh_d = fresh_q;  sp_d = sp_q;  push_en = 1'b0;
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
    tmo_d = tmo_q;  tcnt_d = tcnt_q;
`endif
    case (state_q)
      S_INIT: if (I_CAM_READY) begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: if (I_CMD_VALID) begin
        op_d = I_CMD_OP;  tag_d = I_CMD_TAG;  key_d = I_KEY_DAT;  msk_d = I_EKEY_MSK;
        pri_d = I_KEY_PRI;  val_d = I_KEY_VALUE;
        alloc_d = 1'b0;  rsp_val_d = '0;  rsp_addr_d = '0;
        if (I_CMD_OP[2]) begin
          status_d = ST_ERR;
          state_d  = S_RESP;
        end else begin
          state_d = S_SRCH;
        end
      end
      S_SRCH: begin
        state_d = S_WAIT_S;
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
        tmo_d = TMO_W'(TIMEOUT);
`endif
      end
      S_WAIT_S: if (I_CAM_ACK) begin
        state_d = S_RESP;
        if (I_CAM_ENT_ERR) status_d = ST_ERR;
        else if (op_q == OP_SEARCH) begin
          status_d = cam_hit ? ST_OK : ST_MISS;
          if (cam_hit) begin
            rsp_val_d  = I_CAM_KEY_VALUE;
            rsp_addr_d = I_CAM_SRCH_ADD;
          end
        end else if (cam_hit) begin
          addr_d  = I_CAM_SRCH_ADD;
          state_d = S_ISSUE_W;
        end else if (op_q != OP_WRITE) status_d = ST_MISS;
        else if (pool_empty) status_d = ST_FULL;
        else begin
          // Address is only reserved here; pointers move once the write is acknowledged
          alloc_d    = 1'b1;
          from_stk_d = (sp_q != '0);
          addr_d     = (sp_q != '0) ? stack_top : fresh_q[ADDR_W-1:0];
          state_d    = S_ISSUE_W;
        end
      end
      S_ISSUE_W: begin
        state_d = S_WAIT_W;
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
        tmo_d = TMO_W'(TIMEOUT);
`endif
      end
      S_WAIT_W: if (I_CAM_ACK) begin
        state_d = S_RESP;
        if (I_CAM_ENT_ERR) status_d = ST_ERR;
        else begin
          status_d   = ST_OK;
          rsp_addr_d = addr_q;
          rsp_val_d  = val_q;
          if (alloc_q) begin
            if (from_stk_q) sp_d = sp_q - ONE_C;
            else            fresh_d = fresh_q + ONE_C;
          end
          if (op_q == OP_ERASE && sp_q != DEPTH_C) begin
            push_en = 1'b1;
            sp_d    = sp_q + ONE_C;
          end
        end
      end
      S_RESP: if (I_RSP_READY) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
`ifdef AXONERVE_KVS_ACK_TIMEOUT_EN
    if ((state_q == S_WAIT_S || state_q == S_WAIT_W) && !I_CAM_ACK) begin
      if (tmo_q == '0) begin
        status_d   = ST_ERR;
        rsp_val_d  = '0;
        rsp_addr_d = '0;
        state_d    = S_RESP;
        if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
      end else begin
        tmo_d = tmo_q - TMO_W'(1);
      end
    end
`endif
  end

  assign O_READY         = ready_q;
  assign O_CMD_READY     = (state_q == S_IDLE);
  assign O_RSP_VALID     = (state_q == S_RESP);
  assign O_RSP_TAG       = tag_q;
  assign O_RSP_OP        = op_q;
  assign O_RSP_STATUS    = status_q;
  assign O_RSP_VALUE     = rsp_val_q;
  assign O_RSP_ADDR      = rsp_addr_q;
  assign O_ENT_COUNT     = fresh_q - sp_q;
  assign O_ENT_FULL      = (O_ENT_COUNT == DEPTH_C);
  assign O_CAM_SE        = (state_q == S_SRCH);
  assign O_CAM_WE        = (state_q == S_ISSUE_W) && (op_q != OP_ERASE);
  assign O_CAM_IE        = (state_q == S_ISSUE_W) && (op_q == OP_ERASE);
  assign O_CAM_ADD       = addr_q;
  assign O_CAM_KEY_DAT   = key_q;
  assign O_CAM_EKEY_MSK  = msk_q;
  assign O_CAM_KEY_PRI   = pri_q;
  assign O_CAM_KEY_VALUE = val_q;
endmodule

// File: tb/tb_axonerve_kvs_seq.sv
// tb/tb_axonerve_kvs_seq.sv - randomized bench with a behavioural CAM and a key/pool reference model
module tb_axonerve_kvs_seq;
  localparam int KEY_W = 16, VAL_W = 32, PRI_W = 7, TAG_W = 4, DEPTH = 4, ADDR_W = 2;

  logic I_CLK = 1'b0;
  logic I_XRST = 1'b0;
  logic O_READY, I_CMD_VALID = 1'b0, O_CMD_READY;
  logic [2:0] I_CMD_OP = '0;
  logic [TAG_W-1:0] I_CMD_TAG = '0;
  logic [KEY_W-1:0] I_KEY_DAT = '0, I_EKEY_MSK = '1;
  logic [PRI_W-1:0] I_KEY_PRI = '0;
  logic [VAL_W-1:0] I_KEY_VALUE = '0;
  logic O_RSP_VALID, I_RSP_READY = 1'b0;
  logic [TAG_W-1:0] O_RSP_TAG;
  logic [2:0] O_RSP_OP;
  logic [1:0] O_RSP_STATUS;
  logic [VAL_W-1:0] O_RSP_VALUE;
  logic [ADDR_W-1:0] O_RSP_ADDR;
  logic [ADDR_W:0] O_ENT_COUNT;
  logic O_ENT_FULL, I_CAM_READY = 1'b0;
  logic O_CAM_SE, O_CAM_WE, O_CAM_IE;
  logic [ADDR_W-1:0] O_CAM_ADD;
  logic [KEY_W-1:0] O_CAM_KEY_DAT, O_CAM_EKEY_MSK;
  logic [PRI_W-1:0] O_CAM_KEY_PRI;
  logic [VAL_W-1:0] O_CAM_KEY_VALUE;
  logic I_CAM_ACK = 1'b0, I_CAM_ENT_ERR = 1'b0, I_CAM_SHIT = 1'b0, I_CAM_MHIT = 1'b0;
  logic [ADDR_W-1:0] I_CAM_SRCH_ADD = '0;
  logic [VAL_W-1:0] I_CAM_KEY_VALUE = '0;

  axonerve_kvs_seq #(.KEY_W(KEY_W), .VAL_W(VAL_W), .PRI_W(PRI_W), .TAG_W(TAG_W),
                     .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .I_CLK(I_CLK), .I_XRST(I_XRST), .O_READY(O_READY),
    .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY), .I_CMD_OP(I_CMD_OP),
    .I_CMD_TAG(I_CMD_TAG), .I_KEY_DAT(I_KEY_DAT), .I_EKEY_MSK(I_EKEY_MSK),
    .I_KEY_PRI(I_KEY_PRI), .I_KEY_VALUE(I_KEY_VALUE),
    .O_RSP_VALID(O_RSP_VALID), .I_RSP_READY(I_RSP_READY), .O_RSP_TAG(O_RSP_TAG),
    .O_RSP_OP(O_RSP_OP), .O_RSP_STATUS(O_RSP_STATUS), .O_RSP_VALUE(O_RSP_VALUE),
    .O_RSP_ADDR(O_RSP_ADDR), .O_ENT_COUNT(O_ENT_COUNT), .O_ENT_FULL(O_ENT_FULL),
    .I_CAM_READY(I_CAM_READY), .O_CAM_SE(O_CAM_SE), .O_CAM_WE(O_CAM_WE), .O_CAM_IE(O_CAM_IE),
    .O_CAM_ADD(O_CAM_ADD), .O_CAM_KEY_DAT(O_CAM_KEY_DAT), .O_CAM_EKEY_MSK(O_CAM_EKEY_MSK),
    .O_CAM_KEY_PRI(O_CAM_KEY_PRI), .O_CAM_KEY_VALUE(O_CAM_KEY_VALUE),
    .I_CAM_ACK(I_CAM_ACK), .I_CAM_ENT_ERR(I_CAM_ENT_ERR), .I_CAM_SHIT(I_CAM_SHIT),
    .I_CAM_MHIT(I_CAM_MHIT), .I_CAM_SRCH_ADD(I_CAM_SRCH_ADD), .I_CAM_KEY_VALUE(I_CAM_KEY_VALUE)
  );

  always #5 I_CLK = ~I_CLK;

  int checks = 0, errors = 0;

  // Behavioural CAM: exact-key match, ACK lat_cfg cycles after each request pulse
  logic [KEY_W-1:0] cam_key [DEPTH];
  logic [VAL_W-1:0] cam_val [DEPTH];
  bit cam_vld [DEPTH];
  int lat_cfg = 1;
  bit inj_err = 0;
  int se_n = 0, we_n = 0, ie_n = 0, cam_cnt = 0;
  bit multi_pulse = 0, r_hit = 0, r_err = 0;
  logic [ADDR_W-1:0] r_add = '0;
  logic [VAL_W-1:0] r_val = '0;

  always @(posedge I_CLK) begin
    #1;
    I_CAM_ACK = 0; I_CAM_SHIT = 0; I_CAM_MHIT = 0; I_CAM_ENT_ERR = 0;
    I_CAM_SRCH_ADD = '0; I_CAM_KEY_VALUE = '0;
    if (!I_XRST) begin
      for (int i = 0; i < DEPTH; i++) cam_vld[i] = 0;
      cam_cnt = 0;
    end else begin
      if (int'(O_CAM_SE) + int'(O_CAM_WE) + int'(O_CAM_IE) > 1) multi_pulse = 1;
      if (O_CAM_SE) se_n++;
      if (O_CAM_WE) we_n++;
      if (O_CAM_IE) ie_n++;
      if (cam_cnt > 0) begin
        if (O_CAM_SE | O_CAM_WE | O_CAM_IE) multi_pulse = 1;
        cam_cnt--;
        if (cam_cnt == 0) begin
          I_CAM_ACK = 1; I_CAM_ENT_ERR = r_err;
          if (r_hit) begin
            if ($urandom % 2) I_CAM_SHIT = 1; else I_CAM_MHIT = 1;
            I_CAM_SRCH_ADD = r_add; I_CAM_KEY_VALUE = r_val;
          end
        end
      end else if (O_CAM_SE | O_CAM_WE | O_CAM_IE) begin
        r_hit = 0; r_err = 0; r_add = '0; r_val = '0;
        if (O_CAM_SE)
          for (int i = 0; i < DEPTH; i++)
            if (cam_vld[i] && cam_key[i] == O_CAM_KEY_DAT) begin
              r_hit = 1; r_add = ADDR_W'(i); r_val = cam_val[i];
            end
        if (O_CAM_WE) begin
          r_err = inj_err;
          if (!inj_err) begin
            cam_key[O_CAM_ADD] = O_CAM_KEY_DAT; cam_val[O_CAM_ADD] = O_CAM_KEY_VALUE;
            cam_vld[O_CAM_ADD] = 1;
          end
        end
        if (O_CAM_IE) begin
          r_err = inj_err;
          if (!inj_err) cam_vld[O_CAM_ADD] = 0;
        end
        cam_cnt = lat_cfg;
      end
    end
  end

  // Reference model: key -> (addr, value), LIFO of recycled addresses, fresh counter
  int m_addr [logic [KEY_W-1:0]];
  logic [VAL_W-1:0] m_val [logic [KEY_W-1:0]];
  int free_q [$];
  int fresh = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_CLK); #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [TAG_W-1:0] tag, input logic [KEY_W-1:0] key,
                        input logic [VAL_W-1:0] val, input int lat, input bit inj, input int hold);
    logic [1:0] e_st;
    logic [ADDR_W-1:0] e_addr;
    logic [VAL_W-1:0] e_val;
    int e_we, e_ie, e_se, e_lat, a, n, s0, w0, i0;
    bit hit;
    e_addr = '0; e_val = '0; e_we = 0; e_ie = 0; e_se = (op < 4) ? 1 : 0; e_st = 2'd3;
    hit = m_addr.exists(key);
    if (op == 3'd0) begin
      if (hit) begin e_st = 0; e_addr = ADDR_W'(m_addr[key]); e_val = m_val[key]; end
      else e_st = 1;
    end else if (op == 3'd1 || op == 3'd3) begin
      if (hit) begin
        e_we = 1;
        if (!inj) begin e_st = 0; e_addr = ADDR_W'(m_addr[key]); e_val = val; m_val[key] = val; end
      end else if (op == 3'd3) e_st = 1;
      else if (free_q.size() == 0 && fresh == DEPTH) e_st = 2;
      else begin
        e_we = 1;
        if (!inj) begin
          if (free_q.size() > 0) a = free_q.pop_back();
          else begin a = fresh; fresh++; end
          e_st = 0; e_addr = ADDR_W'(a); e_val = val; m_addr[key] = a; m_val[key] = val;
        end
      end
    end else if (op == 3'd2) begin
      if (hit) begin
        e_ie = 1;
        if (!inj) begin
          e_st = 0; e_addr = ADDR_W'(m_addr[key]); e_val = val;
          free_q.push_back(m_addr[key]); m_addr.delete(key); m_val.delete(key);
        end
      end else e_st = 1;
    end
    e_lat = (op >= 4) ? 1 : (e_we + e_ie > 0) ? 2 * lat + 3 : lat + 2;

    lat_cfg = lat; inj_err = inj; s0 = se_n; w0 = we_n; i0 = ie_n;
    n = 0;
    while (!O_CMD_READY && n < 50) begin tick(); n++; end
    chk("cmd_ready", O_CMD_READY, 1);
    I_CMD_VALID = 1; I_CMD_OP = op; I_CMD_TAG = tag; I_KEY_DAT = key;
    I_KEY_VALUE = val; I_KEY_PRI = PRI_W'($urandom);
    tick();
    I_CMD_VALID = 0; I_KEY_DAT = KEY_W'($urandom); I_KEY_VALUE = $urandom;
    n = 1;
    while (!O_RSP_VALID && n < 100) begin tick(); n++; end
    chk("rsp_latency", n, e_lat);
    chk("rsp_tag", O_RSP_TAG, tag);
    chk("rsp_op", O_RSP_OP, op);
    chk("rsp_status", O_RSP_STATUS, e_st);
    chk("rsp_addr", O_RSP_ADDR, e_addr);
    chk("rsp_value", O_RSP_VALUE, e_val);
    repeat (hold) tick();
    if (hold > 0) begin
      chk("hold_valid", O_RSP_VALID, 1);
      chk("hold_fields", {O_RSP_STATUS, O_RSP_ADDR, O_RSP_VALUE, O_RSP_TAG}, {e_st, e_addr, e_val, tag});
      chk("hold_cmd_ready", O_CMD_READY, 0);
    end
    I_RSP_READY = 1;
    tick();
    I_RSP_READY = 0;
    chk("rsp_gap", O_RSP_VALID, 0);
    chk("se_pulses", se_n - s0, e_se);
    chk("we_pulses", we_n - w0, e_we);
    chk("ie_pulses", ie_n - i0, e_ie);
    chk("ent_count", O_ENT_COUNT, m_addr.num());
    chk("ent_full", O_ENT_FULL, (m_addr.num() == DEPTH) ? 1 : 0);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_ready", O_READY, 0);
    chk("rst_cmd_ready", O_CMD_READY, 0);
    chk("rst_rsp_valid", O_RSP_VALID, 0);
    chk("rst_count", O_ENT_COUNT, 0);
    chk("rst_pulses", {O_CAM_SE, O_CAM_WE, O_CAM_IE}, 0);
    I_XRST = 1;
    repeat (5) tick();
    chk("ready_before_cam", O_READY, 0);
    I_CAM_READY = 1;
    tick();
    chk("ready_after_cam", O_READY, 1);
    chk("ready_count", O_ENT_COUNT, 0);

    do_cmd(3'd1, 4'd3, 16'h1, 32'hAA, 2, 0, 0);
    chk("tp_first_addr", O_RSP_ADDR, 0);
    do_cmd(3'd0, 4'd4, 16'h1, 32'h0, 1, 0, 0);
    chk("tp_search_value", O_RSP_VALUE, 32'hAA);
    do_cmd(3'd1, 4'd5, 16'h2, 32'h22, 1, 0, 0);
    do_cmd(3'd1, 4'd6, 16'h3, 32'h33, 3, 0, 0);
    do_cmd(3'd2, 4'd7, 16'h2, 32'h0, 2, 0, 0);
    chk("tp_erase_addr", O_RSP_ADDR, 1);
    do_cmd(3'd1, 4'd8, 16'h9, 32'h99, 1, 0, 0);
    chk("tp_recycled_addr", O_RSP_ADDR, 1);
    do_cmd(3'd1, 4'd9, 16'h4, 32'h44, 1, 0, 0);
    do_cmd(3'd1, 4'd10, 16'h5, 32'h55, 2, 0, 0);
    chk("tp_full_status", O_RSP_STATUS, 2);
    chk("tp_full_flag", O_ENT_FULL, 1);
    do_cmd(3'd1, 4'd11, 16'h3, 32'h3333, 1, 0, 0);
    chk("tp_overwrite_addr", O_RSP_ADDR, 2);
    do_cmd(3'd3, 4'd12, 16'h55, 32'h1, 1, 0, 0);
    do_cmd(3'd5, 4'd13, 16'h1, 32'h1, 1, 0, 0);
    chk("tp_reserved_status", O_RSP_STATUS, 3);
    do_cmd(3'd0, 4'd14, 16'h9, 32'h0, 2, 0, 10);
    do_cmd(3'd2, 4'd15, 16'h4, 32'h0, 1, 0, 0);
    do_cmd(3'd1, 4'd1, 16'h6, 32'h66, 2, 1, 0);
    do_cmd(3'd1, 4'd2, 16'h6, 32'h66, 2, 0, 0);
    chk("tp_rollback_addr", O_RSP_ADDR, 3);

    for (int k = 0; k < 100; k++)
      do_cmd(($urandom % 10 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4), TAG_W'($urandom),
             KEY_W'(1 + $urandom % 6), $urandom, 1 + $urandom % 3, ($urandom % 12) == 0, $urandom % 3);

    lat_cfg = 3; inj_err = 0;
    I_CMD_VALID = 1; I_CMD_OP = 3'd1; I_KEY_DAT = 16'h77;
    tick();
    I_CMD_VALID = 0;
    tick();
    I_XRST = 0; I_CAM_READY = 0;
    #1;
    chk("midrst_ready", O_READY, 0);
    chk("midrst_count", O_ENT_COUNT, 0);
    chk("midrst_idle", {O_RSP_VALID, O_CMD_READY, O_CAM_SE, O_CAM_WE, O_CAM_IE}, 0);
    m_addr.delete(); m_val.delete(); free_q.delete(); fresh = 0;
    repeat (2) tick();
    I_XRST = 1;
    repeat (2) tick();
    chk("midrst_wait_cam", O_READY, 0);
    I_CAM_READY = 1;
    n = 0;
    while (!O_READY && n < 20) begin tick(); n++; end
    chk("midrst_ready_back", O_READY, 1);
    do_cmd(3'd1, 4'd6, 16'h77, 32'h7777, 1, 0, 0);
    chk("midrst_first_addr", O_RSP_ADDR, 0);
    chk("single_pulse", multi_pulse, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
